i2s_msb_channel_receiver: RTL and testbench
===========================================

I2S_MSB_CHANNEL_RECEIVER -- requirements
Module: i2s_msb_channel_receiver

Interface
REQ-001 SHALL have parameter CIRC_BUF_BITS, default 3, giving the log2 of the number of 256-bit frames held in the circular buffer.
REQ-002 SHALL derive AW = CIRC_BUF_BITS+8 (11 at default) as the buffer address width; depth = 2^AW bits.
REQ-003 clk_x4_i  in  1  sole clock, 4x the serial bit rate; all logic on rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous and active-low.
REQ-005 i2s_running_i  in  1  high while a serial frame stream is present; low = idle or abort.
REQ-006 i2s_data_i  in  1  serial data, MSB-first stream, each bit held 4 clk_x4_i cycles.
REQ-007 read_addr_i  in  AW  buffer read address.
REQ-008 read_data_o  out  1  buffer read data, registered.
REQ-009 ram_write_addr_o  out  AW  buffer write address {frame_ptr, bit_idx}.
REQ-010 ram_write_en_o  out  1  buffer write strobe.
REQ-011 ram_write_data_o  out  1  buffer write data.
REQ-012 last_good_frame_idx_o  out  CIRC_BUF_BITS  index of most recently completed frame.
REQ-013 good_frame_valid_o  out  1  sticky, high once any frame has completed since reset.
REQ-014 frame_done_o  out  1  one-cycle pulse per completed frame.

Function
REQ-015 SHALL contain a 1-bit-wide, 2^AW-deep simple dual-port RAM: write port driven internally by ram_write_*_o, read port by read_addr_i.
REQ-016 RAM write SHALL occur on the clock edge where ram_write_en_o is high, at ram_write_addr_o, with ram_write_data_o.
REQ-017 read_data_o SHALL be RAM[read_addr_i] one clock after read_addr_i is presented; read of the address being written in the same cycle returns old data.
REQ-018 States: IDLE, CAPTURE; internal 2-bit phase counter, 8-bit bit_idx, CIRC_BUF_BITS frame_ptr.
REQ-019 In IDLE, ram_write_addr_o SHALL be {frame_ptr, 8'hFF} and ram_write_en_o low.
REQ-020 IDLE->CAPTURE on the first edge t0 where i2s_running_i is sampled high; phase=0, bit_idx=0 at t0.
REQ-021 In CAPTURE, bit k of the frame SHALL be sampled from i2s_data_i at edge t0+4k+2 (mid-bit), and written with ram_write_en_o high during cycle t0+4k+3 at address {frame_ptr, k}.
REQ-022 ram_write_en_o SHALL be high exactly one cycle per received bit.
REQ-023 After the write of bit 255: frame_done_o pulses one cycle, last_good_frame_idx_o <= frame_ptr, good_frame_valid_o <= 1, frame_ptr increments modulo 2^CIRC_BUF_BITS, bit_idx wraps to 0, phase continues uninterrupted (next frame's bit 0 sampled at t0+1026).
REQ-024 If i2s_running_i is sampled low before bit 255 of the current frame is written: return to IDLE, discard the partial frame, frame_ptr and last_good_frame_idx_o unchanged; next capture overwrites the same frame from bit 0.
REQ-025 i2s_running_i low sampled after bit 255 written and frame completion SHALL return to IDLE with no effect on the completed frame.
REQ-026 frame_ptr wrap from 2^CIRC_BUF_BITS-1 to 0 SHALL overwrite the oldest frame with no stall.

Reset
REQ-027 On rst_n_i low at an edge: state IDLE, frame_ptr=0, bit_idx=0, phase=0, ram_write_en_o=0, ram_write_addr_o=0x0FF, ram_write_data_o=0, last_good_frame_idx_o=0, good_frame_valid_o=0, frame_done_o=0.
REQ-028 Reset SHALL NOT clear RAM contents; read_data_o keeps following the registered read path.
REQ-029 Reset mid-capture SHALL abandon the frame; capture restarts only on a new i2s_running_i high sample after reset release.

Verification
REQ-030 Reset, idle -> ram_write_addr_o=0x0FF, ram_write_en_o=0, last_good_frame_idx_o=0, good_frame_valid_o=0.
REQ-031 Running high for 2048 bits of a random pattern, 4 clocks/bit -> RAM[i]=bit i for i=0..2047, 8 frame_done_o pulses, last_good_frame_idx_o=7, idle address 0x0FF after.
REQ-032 Running dropped after 100 bits -> no frame_done_o, last_good/valid unchanged; next run writes from address 0x000.
REQ-033 9 full frames -> frame 8 lands at 0x000..0x0FF, last_good_frame_idx_o=0.
REQ-034 Reset asserted at bit 50 -> all outputs at reset values, RAM[0..49] retained and readable with 1-cycle latency.
REQ-035 Read and write to address 5 in the same cycle -> read_data_o shows old value, new value on next read.

Source files
------------

// File: rtl/i2s_msb_channel_receiver.sv
// Purpose : deserialises an MSB-first serial frame stream into a circular buffer of 256-bit frames.
// Latency : bit k is sampled 2 clocks into its 4-clock slot and written to the buffer on the next clock; frame_done_o follows the last write by one clock.
// Backpr. : none; the serial stream cannot be stalled. The buffer wraps over the oldest frame, and reads never block writes.
//
// Ports
//   clk_x4_i              sole clock, 4x the serial bit rate
//   rst_n_i               synchronous active-low reset (does not clear buffer contents)
//   i2s_running_i         high while a frame stream is present; low means idle or abort
//   i2s_data_i            serial data, each bit held for 4 clocks
//   read_addr_i           buffer read address
//   read_data_o           buffer read data, valid one clock after read_addr_i
//   ram_write_addr_o      write address {frame_ptr, bit_idx}; {frame_ptr, 8'hFF} when idle
//   ram_write_en_o        write strobe, high for one clock per received bit
//   ram_write_data_o      write data
//   last_good_frame_idx_o index of the most recently completed frame
//   good_frame_valid_o    sticky, high once any frame has completed since reset
//   frame_done_o          one-clock pulse per completed frame
module i2s_msb_channel_receiver #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int AW            = CIRC_BUF_BITS + 8
) (
    input  logic                     clk_x4_i,
    input  logic                     rst_n_i,
    input  logic                     i2s_running_i,
    input  logic                     i2s_data_i,
    input  logic [AW-1:0]            read_addr_i,
    output logic                     read_data_o,
    output logic [AW-1:0]            ram_write_addr_o,
    output logic                     ram_write_en_o,
    output logic                     ram_write_data_o,
    output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
    output logic                     good_frame_valid_o,
    output logic                     frame_done_o
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                   state, state_nxt;
    logic [1:0]               phase, phase_nxt;
    logic [7:0]               bit_idx, bit_idx_nxt;
    logic [CIRC_BUF_BITS-1:0] frame_ptr, frame_ptr_nxt;
    logic [AW-1:0]            wr_addr_nxt;
    logic                     wr_en_nxt;
    logic                     wr_data_nxt;
    logic [CIRC_BUF_BITS-1:0] last_good_nxt;
    logic                     good_valid_nxt;
    logic                     frame_done_nxt;

    // Frame buffer: no reset, so captured frames survive a reset.
    logic mem [0:(1<<AW)-1];

    always_ff @(posedge clk_x4_i) begin
        if (ram_write_en_o) begin
            mem[ram_write_addr_o] <= ram_write_data_o;
        end
        // Non-blocking read returns the pre-write value on a same-address collision.
        read_data_o <= mem[read_addr_i];
    end

    always_ff @(posedge clk_x4_i) begin
        if (!rst_n_i) begin
            state                 <= S_IDLE;
            phase                 <= 2'd0;
            bit_idx               <= 8'd0;
            frame_ptr             <= '0;
            ram_write_addr_o      <= AW'(8'hFF);
            ram_write_en_o        <= 1'b0;
            ram_write_data_o      <= 1'b0;
            last_good_frame_idx_o <= '0;
            good_frame_valid_o    <= 1'b0;
            frame_done_o          <= 1'b0;
        end else begin
            state                 <= state_nxt;
            phase                 <= phase_nxt;
            bit_idx               <= bit_idx_nxt;
            frame_ptr             <= frame_ptr_nxt;
            ram_write_addr_o      <= wr_addr_nxt;
            ram_write_en_o        <= wr_en_nxt;
            ram_write_data_o      <= wr_data_nxt;
            last_good_frame_idx_o <= last_good_nxt;
            good_frame_valid_o    <= good_valid_nxt;
            frame_done_o          <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        bit_idx_nxt    = bit_idx;
        frame_ptr_nxt  = frame_ptr;
        wr_addr_nxt    = ram_write_addr_o;
        wr_en_nxt      = 1'b0;
        wr_data_nxt    = ram_write_data_o;
        last_good_nxt  = last_good_frame_idx_o;
        good_valid_nxt = good_frame_valid_o;
        frame_done_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                wr_addr_nxt = {frame_ptr, 8'hFF};
                if (i2s_running_i) begin
                    state_nxt   = S_CAPTURE;
                    phase_nxt   = 2'd0;
                    bit_idx_nxt = 8'd0;
                end
            end

            S_CAPTURE: begin
                // The buffer write happens on this edge regardless of
                // i2s_running_i, so a frame whose last bit is being written
                // now is complete even if the stream drops at the same edge.
                if (ram_write_en_o) begin
                    bit_idx_nxt = bit_idx + 8'd1;
                    if (bit_idx == 8'hFF) begin
                        frame_done_nxt = 1'b1;
                        last_good_nxt  = frame_ptr;
                        good_valid_nxt = 1'b1;
                        frame_ptr_nxt  = frame_ptr + CIRC_BUF_BITS'(1);
                    end
                end

                if (i2s_running_i) begin
                    phase_nxt = phase + 2'd1;
                    // Phase 1 -> 2 is the middle of the 4-clock bit slot.
                    // The write strobe is never high here, so frame_ptr is stable.
                    if (phase == 2'd1) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = i2s_data_i;
                        wr_addr_nxt = {frame_ptr, bit_idx};
                    end
                end else begin
                    // Abort: a partial frame is discarded by leaving frame_ptr
                    // unchanged, so the next capture overwrites it from bit 0.
                    state_nxt   = S_IDLE;
                    phase_nxt   = 2'd0;
                    bit_idx_nxt = 8'd0;
                    wr_addr_nxt = {frame_ptr_nxt, 8'hFF};
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2s_msb_channel_receiver.sv
module tb_i2s_msb_channel_receiver;

    localparam int CB = 3;
    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          i2s_running;
    logic          i2s_data;
    logic [AW-1:0] read_addr;
    logic          read_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wr_data;
    logic [CB-1:0] last_good;
    logic          good_valid;
    logic          frame_done;

    i2s_msb_channel_receiver #(.CIRC_BUF_BITS(CB)) dut (
        .clk_x4_i              (clk),
        .rst_n_i               (rst_n),
        .i2s_running_i         (i2s_running),
        .i2s_data_i            (i2s_data),
        .read_addr_i           (read_addr),
        .read_data_o           (read_data),
        .ram_write_addr_o      (wr_addr),
        .ram_write_en_o        (wr_en),
        .ram_write_data_o      (wr_data),
        .last_good_frame_idx_o (last_good),
        .good_frame_valid_o    (good_valid),
        .frame_done_o          (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues: expected writes {addr, data}, expected frame indices, expected read data.
    logic [AW:0]   wq[$];
    logic [CB-1:0] dq[$];
    logic          rq[$];

    logic          model [0:2047];
    logic [CB-1:0] exp_fp;
    logic          rd_issue;
    logic          rd_vld_d;
    int            done_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    always @(posedge clk) rd_vld_d <= rd_issue;

    always @(negedge clk) begin
        logic [AW:0] w;
        if (rst_n && wr_en) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {20'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("write_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, w});
            end
        end
        if (rst_n && frame_done) begin
            done_seen++;
            if (dq.size() == 0) begin
                chk("unexpected_frame_done", {29'd0, last_good}, 32'hFFFF_FFFF);
            end else begin
                chk("frame_done_idx", {29'd0, last_good}, {29'd0, dq.pop_front()});
                chk("frame_done_valid", {31'd0, good_valid}, 32'd1);
            end
        end
        if (rd_vld_d) begin
            if (rq.size() == 0) begin
                chk("unexpected_read", {31'd0, read_data}, 32'hFFFF_FFFF);
            end else begin
                chk("read_data", {31'd0, read_data}, {31'd0, rq.pop_front()});
            end
        end
    end

    // Drives n bits starting at the current frame pointer. invert overwrites with
    // the complement of the stored data; probe5 reads address 5 in the cycle it is written.
    task automatic run_bits(input int n, input bit invert, input bit probe5);
        logic [AW-1:0] a;
        logic          b;
        logic          old5;
        old5 = 1'b0;
        @(posedge clk); #1;
        i2s_running = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = {exp_fp, k[7:0]};
            b = invert ? ~model[a] : 1'($urandom_range(0, 1));
            wq.push_back({a, b});
            if (a == AW'(5)) old5 = model[a];
            model[a] = b;
            if (k[7:0] == 8'hFF) begin
                dq.push_back(exp_fp);
                exp_fp = exp_fp + 3'd1;
            end
            i2s_data = b;
            repeat (3) @(posedge clk);
            #1;
            if (probe5 && a == AW'(5)) begin
                read_addr = AW'(5);
                rq.push_back(old5);
                rd_issue  = 1'b1;
            end
            @(posedge clk); #1;
            rd_issue = 1'b0;
        end
        i2s_running = 1'b0;
    endtask

    task automatic read_range(input int lo, input int hi);
        @(posedge clk); #1;
        for (int i = lo; i <= hi; i++) begin
            read_addr = AW'(i);
            rq.push_back(model[i]);
            rd_issue  = 1'b1;
            @(posedge clk); #1;
        end
        rd_issue = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name, input logic [AW-1:0] addr,
                            input logic [CB-1:0] last, input logic valid);
        chk({name, "_addr"},  {21'd0, wr_addr}, {21'd0, addr});
        chk({name, "_en"},    {31'd0, wr_en}, 32'd0);
        chk({name, "_last"},  {29'd0, last_good}, {29'd0, last});
        chk({name, "_valid"}, {31'd0, good_valid}, {31'd0, valid});
        chk({name, "_done"},  {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) model[i] = 1'b0;
        rst_n       = 1'b0;
        i2s_running = 1'b0;
        i2s_data    = 1'b0;
        read_addr   = '0;
        rd_issue    = 1'b0;
        exp_fp      = '0;
        done_seen   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset", AW'(11'h0FF), 3'd0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("idle", AW'(11'h0FF), 3'd0, 1'b0);

        // Abort after 100 bits: nothing completes, pointer stays at frame 0.
        run_bits(100, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk_idle("abort", AW'(11'h0FF), 3'd0, 1'b0);
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Eight full frames fill the whole buffer; the first overwrites the partial frame.
        run_bits(2048, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk_idle("eight_frames", AW'(11'h0FF), 3'd7, 1'b1);
        chk("eight_frames_done_cnt", 32'(done_seen), 32'd8);
        read_range(0, 2047);

        // Ninth frame wraps onto frame 0, with a same-cycle read of address 5.
        run_bits(256, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk_idle("ninth_frame", AW'(11'h1FF), 3'd0, 1'b1);
        read_range(0, 255);

        // Reset after 50 bits of frame 1: outputs clear, RAM keeps the bits.
        run_bits(50, 1'b0, 1'b0);
        rst_n = 1'b0;
        exp_fp = '0;
        @(posedge clk); #1;
        chk_idle("mid_reset", AW'(11'h0FF), 3'd0, 1'b0);
        read_range(256, 305);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_idle("post_reset", AW'(11'h0FF), 3'd0, 1'b0);

        // Capture restarts from frame 0, bit 0.
        run_bits(8, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk_idle("restart", AW'(11'h0FF), 3'd0, 1'b0);
        read_range(0, 7);

        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("done_queue_drained", 32'(dq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        chk("total_done_cnt", 32'(done_seen), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
